// File: rtl/decodificador_7seg_mux.sv
// Scanned 7-segment bus decoder: qualifies each digit dwell, assembles a frame
// of ND nibbles and offers it on a valido/pronto handshake. Optional: ERRO_CONT_EN.
module decodificador_7seg_mux #(
    parameter int ND            = 4,
    parameter int STABLE_CYCLES = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [6:0]      entrada,
    input  logic [ND-1:0]   digit_sel,
    output logic [4*ND-1:0] saida,
    output logic [ND-1:0]   erro,
    output logic            valido,
    input  logic            pronto,
    output logic            sobrecarga
`ifdef ERRO_CONT_EN
    ,
    output logic [7:0]      cont_erro
`endif
);

    // Run counter saturates one past the capture point so a dwell captures once.
    localparam int CW = $clog2(STABLE_CYCLES + 2);
    localparam logic [CW-1:0] CAP = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] SAT = CW'(STABLE_CYCLES + 1);

    typedef enum logic {COLETA, PRONTO} state_t;

    state_t            state;
    logic [6:0]        prev_ent;
    logic [ND-1:0]     prev_sel;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     run;
    logic [4*ND-1:0]   slots;
    logic [4*ND-1:0]   slots_n;
    logic [ND-1:0]     errs;
    logic [ND-1:0]     errs_n;
    logic [ND-1:0]     mask;
    logic [ND-1:0]     mask_n;
    logic [ND-1:0]     cap_bits;
    logic [3:0]        dec_nib;
    logic              dec_bad;
    logic              onehot;
    logic              same;
    logic              cap;
    logic              full;

    // Segment pattern to hex nibble; unknown patterns flag an error.
    always_comb begin
        dec_nib = 4'h0;
        dec_bad = 1'b0;
        case (entrada)
            7'h7E: dec_nib = 4'h0;
            7'h30: dec_nib = 4'h1;
            7'h6D: dec_nib = 4'h2;
            7'h79: dec_nib = 4'h3;
            7'h33: dec_nib = 4'h4;
            7'h5B: dec_nib = 4'h5;
            7'h5F: dec_nib = 4'h6;
            7'h70: dec_nib = 4'h7;
            7'h7F: dec_nib = 4'h8;
            7'h7B: dec_nib = 4'h9;
            7'h77: dec_nib = 4'hA;
            7'h1F: dec_nib = 4'hB;
            7'h4E: dec_nib = 4'hC;
            7'h3D: dec_nib = 4'hD;
            7'h4F: dec_nib = 4'hE;
            7'h47: dec_nib = 4'hF;
            default: begin
                dec_nib = 4'h0;
                dec_bad = 1'b1;
            end
        endcase
    end

    // Length of the current identical one-hot run, including this sample.
    always_comb begin
        onehot = $onehot(digit_sel);
        same   = (entrada == prev_ent) && (digit_sel == prev_sel);
        run    = '0;
        if (onehot) begin
            if (!same)
                run = CW'(1);
            else if (cnt == SAT)
                run = SAT;
            else
                run = cnt + CW'(1);
        end
        cap      = (run == CAP);
        cap_bits = cap ? digit_sel : '0;
    end

    // Slot/error/mask view including this edge's capture, used to publish a frame.
    always_comb begin
        slots_n = slots;
        errs_n  = errs;
        for (int k = 0; k < ND; k++) begin
            if (cap_bits[k]) begin
                slots_n[4*k +: 4] = dec_nib;
                errs_n[k]         = dec_bad;
            end
        end
        mask_n = mask | cap_bits;
        full   = &mask_n;
    end

    // Sample history, run counter and per-digit capture slots.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_ent <= '0;
            prev_sel <= '0;
            cnt      <= '0;
            slots    <= '0;
            errs     <= '0;
        end else begin
            prev_ent <= entrada;
            prev_sel <= digit_sel;
            cnt      <= run;
            slots    <= slots_n;
            errs     <= errs_n;
        end
    end

    // Frame assembly and handshake FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= COLETA;
            mask       <= '0;
            saida      <= '0;
            erro       <= '0;
            valido     <= 1'b0;
            sobrecarga <= 1'b0;
        end else begin
            unique case (state)
                COLETA: begin
                    if (full) begin
                        saida  <= slots_n;
                        erro   <= errs_n;
                        valido <= 1'b1;
                        mask   <= '0;
                        state  <= PRONTO;
                    end else begin
                        mask <= mask_n;
                    end
                end
                PRONTO: begin
                    if (pronto) begin
                        if (full) begin
                            saida <= slots_n;
                            erro  <= errs_n;
                            mask  <= '0;
                        end else begin
                            valido <= 1'b0;
                            mask   <= mask_n;
                            state  <= COLETA;
                        end
                    end else if (full) begin
                        sobrecarga <= 1'b1;
                        mask       <= '0;
                    end else begin
                        mask <= mask_n;
                    end
                end
                default: state <= COLETA;
            endcase
        end
    end

`ifdef ERRO_CONT_EN
    // Saturating count of invalid-pattern captures, dropped frames included.
    always_ff @(posedge clk) begin
        if (rst)
            cont_erro <= 8'h00;
        else if (cap && dec_bad && cont_erro != 8'hFF)
            cont_erro <= cont_erro + 8'd1;
    end
`endif

endmodule

// File: tb/tb_decodificador_7seg_mux.sv
// Directed bench for decodificador_7seg_mux (ND=4, STABLE_CYCLES=3).
// Expected frames are hand-computed from the segment table.
module tb_decodificador_7seg_mux;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  entrada;
    logic [3:0]  digit_sel;
    logic [15:0] saida;
    logic [3:0]  erro;
    logic        valido;
    logic        pronto;
    logic        sobrecarga;
`ifdef ERRO_CONT_EN
    logic [7:0]  cont_erro;
`endif

    int checks = 0;
    int passes = 0;

    decodificador_7seg_mux #(.ND(4), .STABLE_CYCLES(3)) dut (
        .clk(clk),
        .rst(rst),
        .entrada(entrada),
        .digit_sel(digit_sel),
        .saida(saida),
        .erro(erro),
        .valido(valido),
        .pronto(pronto),
        .sobrecarga(sobrecarga)
`ifdef ERRO_CONT_EN
        ,
        .cont_erro(cont_erro)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) passes++;
        else $error("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step(input logic [6:0] e, input logic [3:0] s);
        entrada   = e;
        digit_sel = s;
        @(posedge clk);
        #1;
    endtask

    task automatic dwell(input logic [6:0] e, input logic [3:0] s);
        repeat (3) step(e, s);
    endtask

    task automatic scan(input logic [6:0] a, input logic [6:0] b,
                        input logic [6:0] c, input logic [6:0] d);
        dwell(a, 4'b0001);
        dwell(b, 4'b0010);
        dwell(c, 4'b0100);
        dwell(d, 4'b1000);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(7'h00, 4'b0000);
        step(7'h00, 4'b0000);
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        entrada   = '0;
        digit_sel = '0;
        pronto    = 1'b0;
        do_reset();
        chk("rst_saida", 32'(saida), 32'h0);
        chk("rst_erro", 32'(erro), 32'h0);
        chk("rst_valido", 32'(valido), 32'h0);
        chk("rst_sobre", 32'(sobrecarga), 32'h0);

        // Clean frame with consumer always ready.
        pronto = 1'b1;
        scan(7'h30, 7'h6D, 7'h79, 7'h33);
        chk("f1_valido", 32'(valido), 32'h1);
        chk("f1_saida", 32'(saida), 32'h4321);
        chk("f1_erro", 32'(erro), 32'h0);
        step(7'h00, 4'b0000);
        chk("f1_pulse", 32'(valido), 32'h0);

        // Unstable dwells never capture.
        step(7'h30, 4'b0001); step(7'h7F, 4'b0001); step(7'h30, 4'b0001);
        step(7'h6D, 4'b0010); step(7'h7F, 4'b0010); step(7'h6D, 4'b0010);
        step(7'h79, 4'b0100); step(7'h7F, 4'b0100); step(7'h79, 4'b0100);
        step(7'h33, 4'b1000); step(7'h7F, 4'b1000); step(7'h33, 4'b1000);
        chk("tog_valido", 32'(valido), 32'h0);
        chk("tog_saida", 32'(saida), 32'h4321);

        // Invalid pattern on digit 2.
        scan(7'h30, 7'h6D, 7'h01, 7'h33);
        chk("bad_valido", 32'(valido), 32'h1);
        chk("bad_saida", 32'(saida), 32'h4021);
        chk("bad_erro", 32'(erro), 32'b0100);
`ifdef ERRO_CONT_EN
        chk("bad_cont", 32'(cont_erro), 32'h1);
`endif
        step(7'h00, 4'b0000);
        chk("bad_ack", 32'(valido), 32'h0);

        // Overrun: second frame arrives with no ack.
        pronto = 1'b0;
        scan(7'h30, 7'h6D, 7'h79, 7'h33);
        chk("ov_v1", 32'(valido), 32'h1);
        chk("ov_s1", 32'(saida), 32'h4321);
        chk("ov_nosob", 32'(sobrecarga), 32'h0);
        scan(7'h5B, 7'h5F, 7'h70, 7'h7F);
        chk("ov_saida", 32'(saida), 32'h4321);
        chk("ov_sobre", 32'(sobrecarga), 32'h1);
        chk("ov_valido", 32'(valido), 32'h1);
        pronto = 1'b1;
        step(7'h00, 4'b0000);
        chk("ov_ack", 32'(valido), 32'h0);

        // Ack on the very edge the next frame completes.
        do_reset();
        chk("r2_sobre", 32'(sobrecarga), 32'h0);
        pronto = 1'b0;
        scan(7'h30, 7'h6D, 7'h79, 7'h33);
        chk("bb_v1", 32'(valido), 32'h1);
        dwell(7'h5B, 4'b0001);
        dwell(7'h5F, 4'b0010);
        dwell(7'h70, 4'b0100);
        step(7'h7F, 4'b1000);
        step(7'h7F, 4'b1000);
        pronto = 1'b1;
        step(7'h7F, 4'b1000);
        chk("bb_valido", 32'(valido), 32'h1);
        chk("bb_saida", 32'(saida), 32'h8765);
        chk("bb_sobre", 32'(sobrecarga), 32'h0);
        step(7'h00, 4'b0000);
        chk("bb_ack", 32'(valido), 32'h0);

        // Non one-hot selects never capture.
        repeat (10) step(7'h30, 4'b0011);
        repeat (10) step(7'h30, 4'b0000);
        dwell(7'h6D, 4'b0010);
        dwell(7'h79, 4'b0100);
        dwell(7'h33, 4'b1000);
        chk("oh_valido", 32'(valido), 32'h0);

        // Reset mid-frame discards partial digits.
        do_reset();
        chk("r3_saida", 32'(saida), 32'h0);
        chk("r3_valido", 32'(valido), 32'h0);
        dwell(7'h30, 4'b0001);
        dwell(7'h6D, 4'b0010);
        do_reset();
        dwell(7'h79, 4'b0100);
        dwell(7'h33, 4'b1000);
        chk("mr_valido", 32'(valido), 32'h0);
        dwell(7'h30, 4'b0001);
        dwell(7'h6D, 4'b0010);
        chk("mr_v2", 32'(valido), 32'h1);
        chk("mr_saida", 32'(saida), 32'h4321);
`ifdef ERRO_CONT_EN
        chk("mr_cont", 32'(cont_erro), 32'h0);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
